// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: default widths,
// result-source codes and the saturating Tnew decrement.
package pipe_pkg;

    localparam int PIPE_DW = 32;
    localparam int PIPE_RW = 5;
    localparam int PIPE_TW = 4;

    localparam logic [1:0] WSRC_AO  = 2'd0;
    localparam logic [1:0] WSRC_DR  = 2'd1;
    localparam logic [1:0] WSRC_PC8 = 2'd2;

    // Tnew counts down as the instruction ages but never wraps below zero.
    function automatic logic [31:0] tnew_dec(input logic [31:0] t);
        return (t == 32'd0) ? 32'd0 : t - 32'd1;
    endfunction

endpackage

// File: rtl/wb_data_sel.sv
// Write-back data select: picks ALU result, memory data or the link address.
module wb_data_sel
    import pipe_pkg::*;
#(
    parameter int DW      = PIPE_DW,
    parameter int PC8_OFF = 8
) (
    input  logic [1:0]    wsrc,
    input  logic [DW-1:0] ao,
    input  logic [DW-1:0] dr,
    input  logic [DW-1:0] pc,
    output logic [DW-1:0] wdata
);

    always_comb begin
        wdata = ao;
        case (wsrc)
            WSRC_DR:  wdata = dr;
            WSRC_PC8: wdata = pc + DW'(PC8_OFF);
            default:  wdata = ao;
        endcase
    end

endmodule

// File: rtl/mw_pipe_reg.sv
// MEM->WB stage register with stall/flush, valid tracking, retire counter
// and the forwarding view (we/wreg/wdata/tnew) of the held instruction.
module mw_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DW      = PIPE_DW,
    parameter int RW      = PIPE_RW,
    parameter int TW      = PIPE_TW,
    parameter int CW      = 32,
    parameter int PC8_OFF = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_ir,
    input  logic [DW-1:0] in_pc,
    input  logic [DW-1:0] in_ao,
    input  logic [DW-1:0] in_dr,
    input  logic [RW-1:0] in_wreg,
    input  logic [1:0]    in_wsrc,
    input  logic [TW-1:0] in_tnew,
    output logic          out_valid,
    output logic [DW-1:0] out_ir,
    output logic [DW-1:0] out_pc,
    output logic [DW-1:0] out_ao,
    output logic [DW-1:0] out_dr,
    output logic [RW-1:0] out_wreg,
    output logic          out_we,
    output logic [DW-1:0] out_wdata,
    output logic [TW-1:0] out_tnew,
    output logic [CW-1:0] retire_cnt
);

    logic          valid_q;
    logic [DW-1:0] ir_q;
    logic [DW-1:0] pc_q;
    logic [DW-1:0] ao_q;
    logic [DW-1:0] dr_q;
    logic [RW-1:0] wreg_q;
    logic [1:0]    wsrc_q;
    logic [TW-1:0] tnew_q;
    logic [CW-1:0] retire_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            ir_q     <= '0;
            pc_q     <= '0;
            ao_q     <= '0;
            dr_q     <= '0;
            wreg_q   <= '0;
            wsrc_q   <= '0;
            tnew_q   <= '0;
            retire_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ir_q    <= '0;
            pc_q    <= '0;
            ao_q    <= '0;
            dr_q    <= '0;
            wreg_q  <= '0;
            wsrc_q  <= '0;
            tnew_q  <= '0;
        end else if (stall) begin
            // Contents hold, but the held result still ages by one cycle.
            tnew_q <= TW'(tnew_dec(32'(tnew_q)));
        end else begin
            valid_q  <= in_valid;
            ir_q     <= in_ir;
            pc_q     <= in_pc;
            ao_q     <= in_ao;
            dr_q     <= in_dr;
            wreg_q   <= in_valid ? in_wreg : '0;
            wsrc_q   <= in_wsrc;
            tnew_q   <= TW'(tnew_dec(32'(in_tnew)));
            retire_q <= retire_q + CW'(in_valid);
        end
    end

    wb_data_sel #(
        .DW      (DW),
        .PC8_OFF (PC8_OFF)
    ) u_wb_data_sel (
        .wsrc  (wsrc_q),
        .ao    (ao_q),
        .dr    (dr_q),
        .pc    (pc_q),
        .wdata (out_wdata)
    );

    assign out_valid  = valid_q;
    assign out_ir     = ir_q;
    assign out_pc     = pc_q;
    assign out_ao     = ao_q;
    assign out_dr     = dr_q;
    assign out_wreg   = wreg_q;
    assign out_we     = valid_q && (wreg_q != '0);
    assign out_tnew   = tnew_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_mw_pipe_reg.sv
// Directed bench for mw_pipe_reg with a 4-bit retire counter so wrap is reachable.
module tb_mw_pipe_reg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TW = 4;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          stall;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_ir;
    logic [DW-1:0] in_pc;
    logic [DW-1:0] in_ao;
    logic [DW-1:0] in_dr;
    logic [RW-1:0] in_wreg;
    logic [1:0]    in_wsrc;
    logic [TW-1:0] in_tnew;
    logic          out_valid;
    logic [DW-1:0] out_ir;
    logic [DW-1:0] out_pc;
    logic [DW-1:0] out_ao;
    logic [DW-1:0] out_dr;
    logic [RW-1:0] out_wreg;
    logic          out_we;
    logic [DW-1:0] out_wdata;
    logic [TW-1:0] out_tnew;
    logic [CW-1:0] retire_cnt;

    int checks   = 0;
    int failures = 0;

    mw_pipe_reg #(
        .DW      (DW),
        .RW      (RW),
        .TW      (TW),
        .CW      (CW),
        .PC8_OFF (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ir      (in_ir),
        .in_pc      (in_pc),
        .in_ao      (in_ao),
        .in_dr      (in_dr),
        .in_wreg    (in_wreg),
        .in_wsrc    (in_wsrc),
        .in_tnew    (in_tnew),
        .out_valid  (out_valid),
        .out_ir     (out_ir),
        .out_pc     (out_pc),
        .out_ao     (out_ao),
        .out_dr     (out_dr),
        .out_wreg   (out_wreg),
        .out_we     (out_we),
        .out_wdata  (out_wdata),
        .out_tnew   (out_tnew),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] ir, input logic [DW-1:0] pc,
                         input logic [DW-1:0] ao, input logic [DW-1:0] dr,
                         input logic [RW-1:0] wreg, input logic [1:0] wsrc,
                         input logic [TW-1:0] tnew);
        in_valid = v;
        in_ir    = ir;
        in_pc    = pc;
        in_ao    = ao;
        in_dr    = dr;
        in_wreg  = wreg;
        in_wsrc  = wsrc;
        in_tnew  = tnew;
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0, 2'd0, '0);
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_retire", 64'(retire_cnt), 64'd0);
        chk("rst_tnew", 64'(out_tnew), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Load from DR
        drive(1'b1, 32'h11, 32'h1000, 32'h55, 32'hDEADBEEF, 5'd8, 2'd1, 4'd1);
        step();
        chk("adv_we", 64'(out_we), 64'd1);
        chk("adv_wreg", 64'(out_wreg), 64'd8);
        chk("adv_wdata", 64'(out_wdata), 64'hDEADBEEF);
        chk("adv_tnew", 64'(out_tnew), 64'd0);
        chk("adv_retire", 64'(retire_cnt), 64'd1);
        chk("adv_ir", 64'(out_ir), 64'h11);

        // Link write-back, tnew=0 saturates
        drive(1'b1, 32'h22, 32'h00003000, 32'h66, 32'h77, 5'd31, 2'd2, 4'd0);
        step();
        chk("link_wdata", 64'(out_wdata), 64'h00003008);
        chk("link_wreg", 64'(out_wreg), 64'd31);
        chk("link_tnew", 64'(out_tnew), 64'd0);
        chk("link_retire", 64'(retire_cnt), 64'd2);

        drive(1'b1, 32'h33, 32'h4000, 32'hA5A5, 32'h99, 5'd3, 2'd0, 4'd2);
        step();
        chk("ao0_wdata", 64'(out_wdata), 64'hA5A5);
        chk("ao0_tnew", 64'(out_tnew), 64'd1);

        drive(1'b1, 32'h44, 32'h5000, 32'h1234, 32'h98, 5'd3, 2'd3, 4'd0);
        step();
        chk("ao3_wdata", 64'(out_wdata), 64'h1234);
        chk("ao3_retire", 64'(retire_cnt), 64'd4);

        // Stall ages tnew while everything else holds
        drive(1'b1, 32'hCAFE, 32'h6000, 32'h77, 32'h88, 5'd4, 2'd0, 4'd3);
        step();
        chk("stl_load_tnew", 64'(out_tnew), 64'd2);
        chk("stl_load_retire", 64'(retire_cnt), 64'd5);
        stall = 1'b1;
        drive(1'b1, 32'hFFFF, 32'h7000, 32'hEE, 32'hDD, 5'd9, 2'd1, 4'd7);
        step();
        chk("stl1_tnew", 64'(out_tnew), 64'd1);
        in_ir = 32'hBEEF;
        in_ao = 32'h1111;
        step();
        chk("stl2_tnew", 64'(out_tnew), 64'd0);
        step();
        chk("stl3_tnew", 64'(out_tnew), 64'd0);
        chk("stl_ir", 64'(out_ir), 64'hCAFE);
        chk("stl_wdata", 64'(out_wdata), 64'h77);
        chk("stl_wreg", 64'(out_wreg), 64'd4);
        chk("stl_retire", 64'(retire_cnt), 64'd5);

        // Flush wins over stall
        flush = 1'b1;
        step();
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_wreg", 64'(out_wreg), 64'd0);
        chk("fl_we", 64'(out_we), 64'd0);
        chk("fl_tnew", 64'(out_tnew), 64'd0);
        chk("fl_ir", 64'(out_ir), 64'd0);
        chk("fl_pc", 64'(out_pc), 64'd0);
        chk("fl_retire", 64'(retire_cnt), 64'd5);
        flush = 1'b0;
        stall = 1'b0;

        drive(1'b1, 32'h55, 32'h8000, 32'h12, 32'h34, 5'd0, 2'd0, 4'd0);
        step();
        chk("r0_valid", 64'(out_valid), 64'd1);
        chk("r0_we", 64'(out_we), 64'd0);
        chk("r0_retire", 64'(retire_cnt), 64'd6);

        drive(1'b0, 32'h66, 32'h9000, 32'h12, 32'h34, 5'd5, 2'd0, 4'd0);
        step();
        chk("inv_wreg", 64'(out_wreg), 64'd0);
        chk("inv_we", 64'(out_we), 64'd0);
        chk("inv_retire", 64'(retire_cnt), 64'd6);

        // Counter wrap from a fresh reset
        reset = 1'b0;
        #1;
        reset = 1'b1;
        chk("wrap_start", 64'(retire_cnt), 64'd0);
        drive(1'b1, 32'h77, 32'hA000, 32'h1, 32'h2, 5'd8, 2'd0, 4'd5);
        for (int i = 0; i < 15; i++) step();
        chk("wrap_15", 64'(retire_cnt), 64'd15);
        step();
        chk("wrap_16", 64'(retire_cnt), 64'd0);
        chk("pre_arst_tnew", 64'(out_tnew), 64'd4);

        // Asynchronous reset mid-cycle, no clock edge in between
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_we", 64'(out_we), 64'd0);
        chk("arst_tnew", 64'(out_tnew), 64'd0);
        chk("arst_retire", 64'(retire_cnt), 64'd0);
        chk("arst_wdata", 64'(out_wdata), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
